mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one memory bus (valid / data_ok handshake, dbus-style fields) between NREQ requesters, e.g. instruction fetch and the memory stage.
- Latches the winning request, drives the shared bus from the latched copy and holds it until the bus returns data_ok.
- Routes the response back to the granted requester only.
- Sits between the pipeline's bus masters and the single cache/memory port.

Parameters:
- NREQ, 2, number of requesters; index 0 has highest fixed priority.
- AW, 64, address width.
- DW, 64, data width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid; held until that requester's resp_data_ok
- req_addr  input  NREQ*AW  request addresses; slice i belongs to requester i
- req_size  input  NREQ*3  msize encoding, passed through unchanged
- req_strobe  input  NREQ*(DW/8)  write strobes; all zero means read
- req_data  input  NREQ*DW  write data
- resp_data_ok  output  NREQ  one-hot completion pulse to the granted requester
- resp_data  output  DW  read data, broadcast to all requesters
- bus_valid  output  1  shared bus request valid
- bus_addr  output  AW  latched address
- bus_size  output  3  latched size
- bus_strobe  output  DW/8  latched strobe
- bus_data  output  DW  latched write data
- bus_data_ok  input  1  bus completion
- bus_rdata  input  DW  bus read data
- grant  output  NREQ  one-hot current owner; 0 when idle
- busy  output  1  high in BUSY state

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - grant = 0.
  - bus_valid = 0.
  - All latched fields = 0.
  - Round-robin pointer = 0.
- States:
  - IDLE: no owner.
  - BUSY: owner held in grant; bus fields driven from registers.
- IDLE → BUSY: at any edge where some req_valid is high.
  - Winner is chosen by the priority rule.
  - Winner's addr/size/strobe/data are registered.
  - grant is set one-hot.
- Latency: req_valid first seen at edge t gives bus_valid = 1 in cycle t+1. Minimum request-to-data_ok latency is 2 cycles.
- In BUSY:
  - bus_valid = 1 and all bus fields stay constant until bus_data_ok.
  - Changes on req_* inputs are ignored.
- bus_data_ok cycle:
  - resp_data_ok = grant, combinationally in the same cycle.
  - resp_data = bus_rdata, combinationally.
  - resp_data_ok is 0 for every index at all other times.
- Back-to-back: in the data_ok cycle, any other requester with req_valid is arbitrated.
  - The completing index is excluded from this arbitration (its valid still shows the finished request).
  - If a winner exists, the state stays BUSY with the new grant and latched fields at the next edge; no idle bubble.
  - Otherwise the state goes to IDLE.
- Requester drops req_valid mid-transaction (e.g. flush): the transaction still completes on the bus, and the resp_data_ok pulse is still issued to that index.
- bus_data_ok while IDLE: ignored; no resp pulse.
- Reset asserted while BUSY: the transaction is abandoned. At the next edge bus_valid = 0, grant = 0, state = IDLE.
- Simultaneous requests in IDLE: resolved by the priority rule only, never by arrival order.

Optional Feature:
- Macro: MEM_BUS_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Pointer = index after the last granted index, mod NREQ; updated on every grant.
  - Search starts at the pointer.
  - Back-to-back exclusion still applies.
- Undefined: fixed priority, lowest index wins; no pointer register.

Test Plan:
- Single read: NREQ=2, req_valid=2'b10, addr=0x40600008, strobe=0 at cycle 0 → bus_valid at cycle 1 with addr 0x40600008. bus_data_ok at cycle 3 with rdata=0xDEADBEEF → resp_data_ok=2'b10 and resp_data=0xDEADBEEF in cycle 3; bus_valid=0 in cycle 4.
- Simultaneous requests: both valid at cycle 0, req0 addr 0x1000, req1 addr 0x2000.
  - Fixed priority: grant=01 first with bus_addr 0x1000; on its data_ok, grant=10 at the next edge with bus_addr 0x2000 and no idle cycle.
  - Completing req0 is not regranted.
- Stability: while BUSY, change req_addr of the owner to 0x9999 → bus_addr remains the latched 0x1000 until data_ok.
- Flush: owner drops req_valid the cycle after grant → bus_valid stays 1; resp_data_ok pulses on that index when bus_data_ok=1; then IDLE.
- Reset mid-transaction: assert reset during BUSY → next cycle bus_valid=0, grant=0, busy=0. A later bus_data_ok produces no resp pulse.
- MEM_BUS_ARB_RR_EN defined: both requesters held continuously valid → grants alternate 01,10,01,10 across four transactions.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester, shared-bus and status signals for mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_bus_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 64,
  parameter int DW   = 64
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*AW-1:0]       req_addr;
  logic [NREQ*3-1:0]        req_size;
  logic [NREQ*(DW/8)-1:0]   req_strobe;
  logic [NREQ*DW-1:0]       req_data;
  logic [NREQ-1:0]          resp_data_ok;
  logic [DW-1:0]            resp_data;
  logic                     bus_valid;
  logic [AW-1:0]            bus_addr;
  logic [2:0]               bus_size;
  logic [DW/8-1:0]          bus_strobe;
  logic [DW-1:0]            bus_data;
  logic                     bus_data_ok;
  logic [DW-1:0]            bus_rdata;
  logic [NREQ-1:0]          grant;
  logic                     busy;

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    input  bus_data_ok, bus_rdata,
    output resp_data_ok, resp_data,
    output bus_valid, bus_addr, bus_size, bus_strobe, bus_data,
    output grant, busy
  );

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    output bus_data_ok, bus_rdata,
    input  resp_data_ok, resp_data,
    input  bus_valid, bus_addr, bus_size, bus_strobe, bus_data,
    input  grant, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one valid/data_ok memory bus between NREQ requesters, holding the latched winner until data_ok.
// Define MEM_BUS_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_bus_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 64,
  parameter int DW   = 64
) (
  input  logic            clk,
  input  logic            reset,
  mem_bus_arbiter_if.slave bif
);
  localparam int SW = DW / 8;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]      state;
  logic [NREQ-1:0] grant_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      size_q;
  logic [SW-1:0]   strobe_q;
  logic [DW-1:0]   data_q;

  logic            done;
  logic            arb_en;
  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;

  // The completing owner still shows req_valid for its finished request, so mask it out.
  assign done     = (state == BUSY) && bif.bus_data_ok;
  assign arb_en   = (state == IDLE) || done;
  assign eligible = arb_en ? (bif.req_valid & ~grant_q) : '0;

`ifdef MEM_BUS_ARB_RR_EN
  logic [PW-1:0] ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (arb_en && win_found) begin
      ptr_q <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'(i);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // A winner found at data_ok hands the bus straight over, avoiding an idle bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
    end else if (arb_en) begin
      if (win_found) begin
        state    <= BUSY;
        grant_q  <= NREQ'(1) << win_idx;
        addr_q   <= bif.req_addr[win_idx*AW +: AW];
        size_q   <= bif.req_size[win_idx*3 +: 3];
        strobe_q <= bif.req_strobe[win_idx*SW +: SW];
        data_q   <= bif.req_data[win_idx*DW +: DW];
      end else begin
        state   <= IDLE;
        grant_q <= '0;
      end
    end
  end

  assign bif.busy         = (state == BUSY);
  assign bif.bus_valid    = (state == BUSY);
  assign bif.grant        = grant_q;
  assign bif.bus_addr     = addr_q;
  assign bif.bus_size     = size_q;
  assign bif.bus_strobe   = strobe_q;
  assign bif.bus_data     = data_q;
  assign bif.resp_data_ok = done ? grant_q : '0;
  assign bif.resp_data    = bif.bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (NREQ=2); each row is one clock cycle.
// Rows hold inputs for the cycle and the outputs expected during that cycle.
module tb_mem_bus_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 64;
  localparam int DW   = 64;

  localparam logic [2:0]  SIZE0 = 3'd3;
  localparam logic [7:0]  STRB0 = 8'hFF;
  localparam logic [63:0] DATA0 = 64'h1111_2222_3333_4444;
  localparam logic [2:0]  SIZE1 = 3'd2;
  localparam logic [7:0]  STRB1 = 8'h00;
  localparam logic [63:0] DATA1 = 64'h5555_6666_7777_8888;

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic [63:0] a0;
    logic [63:0] a1;
    logic        dok;
    logic [63:0] rdata;
    logic        ebv;
    logic [1:0]  egr;
    logic [63:0] eaddr;
    logic [1:0]  eok;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  vec_t vecs[31];

  mem_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif ();

  mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset           = v.rst;
    bif.req_valid   = v.rv;
    bif.req_addr    = {v.a1, v.a0};
    bif.req_size    = {SIZE1, SIZE0};
    bif.req_strobe  = {STRB1, STRB0};
    bif.req_data    = {DATA1, DATA0};
    bif.bus_data_ok = v.dok;
    bif.bus_rdata   = v.rdata;
  endtask

  // Drive just after the rising edge, compare at the falling edge, then advance one cycle.
  task automatic stepCheck(input vec_t v, input string tag);
    applyStimulus(v);
    @(negedge clk);
    checkOutput({tag, " bus_valid"}, 64'(bif.bus_valid), 64'(v.ebv));
    checkOutput({tag, " busy"}, 64'(bif.busy), 64'(v.ebv));
    checkOutput({tag, " grant"}, 64'(bif.grant), 64'(v.egr));
    checkOutput({tag, " resp_data_ok"}, 64'(bif.resp_data_ok), 64'(v.eok));
    if (v.ebv) begin
      checkOutput({tag, " bus_addr"}, bif.bus_addr, v.eaddr);
      checkOutput({tag, " bus_size"}, 64'(bif.bus_size), (v.egr == 2'b01) ? 64'(SIZE0) : 64'(SIZE1));
      checkOutput({tag, " bus_strobe"}, 64'(bif.bus_strobe), (v.egr == 2'b01) ? 64'(STRB0) : 64'(STRB1));
      checkOutput({tag, " bus_data"}, bif.bus_data, (v.egr == 2'b01) ? DATA0 : DATA1);
    end
    if (v.eok != 2'b00) begin
      checkOutput({tag, " resp_data"}, bif.resp_data, v.rdata);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    // single read by requester 1
    vecs[0]  = '{1'b0, 2'b10, 64'h0,    64'h4060_0008, 1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[1]  = '{1'b0, 2'b10, 64'h0,    64'h4060_0008, 1'b0, 64'h0,         1'b1, 2'b10, 64'h4060_0008, 2'b00};
    vecs[2]  = '{1'b0, 2'b10, 64'h0,    64'h4060_0008, 1'b0, 64'h0,         1'b1, 2'b10, 64'h4060_0008, 2'b00};
    vecs[3]  = '{1'b0, 2'b10, 64'h0,    64'h4060_0008, 1'b1, 64'hDEAD_BEEF, 1'b1, 2'b10, 64'h4060_0008, 2'b10};
    vecs[4]  = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    // simultaneous requests, owner address change ignored, back-to-back handover
    vecs[5]  = '{1'b1, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[6]  = '{1'b0, 2'b11, 64'h1000, 64'h2000,      1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[7]  = '{1'b0, 2'b11, 64'h9999, 64'h2000,      1'b0, 64'h0,         1'b1, 2'b01, 64'h1000,      2'b00};
    vecs[8]  = '{1'b0, 2'b11, 64'h9999, 64'h2000,      1'b0, 64'h0,         1'b1, 2'b01, 64'h1000,      2'b00};
    vecs[9]  = '{1'b0, 2'b11, 64'h9999, 64'h2000,      1'b1, 64'hCAFE,      1'b1, 2'b01, 64'h1000,      2'b01};
    vecs[10] = '{1'b0, 2'b10, 64'h0,    64'h2000,      1'b0, 64'h0,         1'b1, 2'b10, 64'h2000,      2'b00};
    vecs[11] = '{1'b0, 2'b10, 64'h0,    64'h2000,      1'b1, 64'hBEEF,      1'b1, 2'b10, 64'h2000,      2'b10};
    vecs[12] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    // completing requester still shows valid but is not regranted
    vecs[13] = '{1'b0, 2'b01, 64'h3000, 64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[14] = '{1'b0, 2'b01, 64'h3000, 64'h0,         1'b0, 64'h0,         1'b1, 2'b01, 64'h3000,      2'b00};
    vecs[15] = '{1'b0, 2'b01, 64'h3000, 64'h0,         1'b1, 64'h55,        1'b1, 2'b01, 64'h3000,      2'b01};
    vecs[16] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    // flush: owner drops valid right after grant
    vecs[17] = '{1'b0, 2'b10, 64'h0,    64'h4000,      1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[18] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b1, 2'b10, 64'h4000,      2'b00};
    vecs[19] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b1, 2'b10, 64'h4000,      2'b00};
    vecs[20] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b1, 64'h77,        1'b1, 2'b10, 64'h4000,      2'b10};
    vecs[21] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    // data_ok while idle is ignored
    vecs[22] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b1, 64'h99,        1'b0, 2'b00, 64'h0,         2'b00};
    // reset mid-transaction, later data_ok gives no pulse
    vecs[23] = '{1'b0, 2'b01, 64'h5000, 64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[24] = '{1'b0, 2'b01, 64'h5000, 64'h0,         1'b0, 64'h0,         1'b1, 2'b01, 64'h5000,      2'b00};
    vecs[25] = '{1'b1, 2'b01, 64'h5000, 64'h0,         1'b0, 64'h0,         1'b1, 2'b01, 64'h5000,      2'b00};
    vecs[26] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[27] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b1, 64'hAA,        1'b0, 2'b00, 64'h0,         2'b00};
    // minimum two-cycle request-to-data_ok latency
    vecs[28] = '{1'b0, 2'b10, 64'h0,    64'h6000,      1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};
    vecs[29] = '{1'b0, 2'b10, 64'h0,    64'h6000,      1'b1, 64'h1234,      1'b1, 2'b10, 64'h6000,      2'b10};
    vecs[30] = '{1'b0, 2'b00, 64'h0,    64'h0,         1'b0, 64'h0,         1'b0, 2'b00, 64'h0,         2'b00};

    // reset state, with requests present to show they are ignored under reset
    applyStimulus('{1'b1, 2'b11, 64'h1, 64'h2, 1'b1, 64'h0, 1'b0, 2'b00, 64'h0, 2'b00});
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset bus_valid", 64'(bif.bus_valid), 64'h0);
    checkOutput("reset grant", 64'(bif.grant), 64'h0);
    checkOutput("reset busy", 64'(bif.busy), 64'h0);
    checkOutput("reset resp_data_ok", 64'(bif.resp_data_ok), 64'h0);
    checkOutput("reset bus_addr", bif.bus_addr, 64'h0);
    checkOutput("reset bus_size", 64'(bif.bus_size), 64'h0);
    checkOutput("reset bus_strobe", 64'(bif.bus_strobe), 64'h0);
    checkOutput("reset bus_data", bif.bus_data, 64'h0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 31; k++) begin
      stepCheck(vecs[k], $sformatf("v%0d", k));
    end

    // both requesters held valid: grants alternate 01,10,01,10 via completion exclusion
    stepCheck('{1'b1, 2'b00, 64'h0,    64'h0,    1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "alt0");
    stepCheck('{1'b0, 2'b11, 64'h7100, 64'h7200, 1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "alt1");
    stepCheck('{1'b0, 2'b11, 64'h7100, 64'h7200, 1'b1, 64'hA1, 1'b1, 2'b01, 64'h7100, 2'b01}, "alt2");
    stepCheck('{1'b0, 2'b11, 64'h7100, 64'h7200, 1'b1, 64'hA2, 1'b1, 2'b10, 64'h7200, 2'b10}, "alt3");
    stepCheck('{1'b0, 2'b11, 64'h7100, 64'h7200, 1'b1, 64'hA3, 1'b1, 2'b01, 64'h7100, 2'b01}, "alt4");
    stepCheck('{1'b0, 2'b11, 64'h7100, 64'h7200, 1'b1, 64'hA4, 1'b1, 2'b10, 64'h7200, 2'b10}, "alt5");
    stepCheck('{1'b0, 2'b00, 64'h0,    64'h0,    1'b0, 64'h0,  1'b1, 2'b01, 64'h7100, 2'b00}, "alt6");
    stepCheck('{1'b0, 2'b00, 64'h0,    64'h0,    1'b1, 64'hA5, 1'b1, 2'b01, 64'h7100, 2'b01}, "alt7");
    stepCheck('{1'b0, 2'b00, 64'h0,    64'h0,    1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "alt8");

    // after a lone grant to requester 0, a simultaneous pair shows the arbitration policy
    stepCheck('{1'b1, 2'b00, 64'h0,    64'h0,    1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "pol0");
    stepCheck('{1'b0, 2'b01, 64'h7000, 64'h0,    1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "pol1");
    stepCheck('{1'b0, 2'b01, 64'h7000, 64'h0,    1'b1, 64'hB1, 1'b1, 2'b01, 64'h7000, 2'b01}, "pol2");
    stepCheck('{1'b0, 2'b00, 64'h0,    64'h0,    1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "pol3");
    stepCheck('{1'b0, 2'b11, 64'h7000, 64'h8000, 1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "pol4");
`ifdef MEM_BUS_ARB_RR_EN
    stepCheck('{1'b0, 2'b00, 64'h0,    64'h0,    1'b1, 64'hB2, 1'b1, 2'b10, 64'h8000, 2'b10}, "pol5");
`else
    stepCheck('{1'b0, 2'b00, 64'h0,    64'h0,    1'b1, 64'hB2, 1'b1, 2'b01, 64'h7000, 2'b01}, "pol5");
`endif
    stepCheck('{1'b0, 2'b00, 64'h0,    64'h0,    1'b0, 64'h0,  1'b0, 2'b00, 64'h0,    2'b00}, "pol6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
